// File: rtl/multi_dataflow_tile_ctrl.sv
// Tile-level sequencer for the multi_dataflow HWPE.
// Steps the engine and the inStream0/outStream0 streamers through NB_ITER tiles,
// advancing the tile addresses by their strides, and emits one done event per job.
module multi_dataflow_tile_ctrl #(
  parameter int unsigned CNT_LEN   = 1024,
  parameter int unsigned NB_ITER_W = 16,
  parameter int unsigned ADDR_W    = 32,
  localparam int unsigned CNT_W    = $clog2(CNT_LEN) + 1
) (
  input  logic                 clk_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [NB_ITER_W-1:0] nb_iter_i,
  input  logic [ADDR_W-1:0]    instream0_base_i,
  input  logic [ADDR_W-1:0]    outstream0_base_i,
  input  logic [ADDR_W-1:0]    instream0_tile_stride_i,
  input  logic [ADDR_W-1:0]    outstream0_tile_stride_i,
  input  logic [CNT_W-1:0]     cnt_limit_i,
  input  logic                 instream0_ready_i,
  input  logic                 outstream0_ready_i,
  input  logic                 outstream0_done_i,
  input  logic [CNT_W-1:0]     engine_cnt_i,
  input  logic                 engine_done_i,
  output logic                 instream0_req_start_o,
  output logic [ADDR_W-1:0]    instream0_addr_o,
  output logic                 outstream0_req_start_o,
  output logic [ADDR_W-1:0]    outstream0_addr_o,
  output logic                 engine_clear_o,
  output logic                 engine_enable_o,
  output logic                 engine_start_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [NB_ITER_W-1:0] iter_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;
  localparam logic [2:0] S_UPDATE  = 3'd5;
  localparam logic [2:0] S_FINISH  = 3'd6;

  logic [2:0]           state_q;
  logic [2:0]           state_d;

  // Job configuration latched at start
  logic [NB_ITER_W-1:0] nb_iter_q;
  logic [CNT_W-1:0]     cnt_limit_q;
  logic [ADDR_W-1:0]    in_stride_q;
  logic [ADDR_W-1:0]    out_stride_q;

  // Per-tile progress
  logic [NB_ITER_W-1:0] iter_q;
  logic [ADDR_W-1:0]    in_addr_q;
  logic [ADDR_W-1:0]    out_addr_q;
  logic                 sink_done_seen_q;

  // Registered output decodes
  logic                 clear_q;
  logic                 fire_q;
  logic                 enable_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 fire_d;
  logic                 both_ready_c;
  logic                 limit_hit_c;
  logic                 last_tile_c;

  assign both_ready_c = instream0_ready_i && outstream0_ready_i;
  assign limit_hit_c  = (cnt_limit_q != '0) && (engine_cnt_i >= cnt_limit_q);
  assign last_tile_c  = (iter_q + NB_ITER_W'(1)) == nb_iter_q;

  // State register
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-cycle start-triplet decode.
  // The triplet is registered: it is armed on the edge that samples both
  // ready flags high and is visible during the following LAUNCH cycle,
  // after which LAUNCH leaves for COMPUTE.
  always_comb begin
    state_d = state_q;
    fire_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = (nb_iter_i == '0) ? S_FINISH : S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = S_LAUNCH;
        fire_d  = both_ready_c;
      end
      S_LAUNCH: begin
        if (fire_q) begin
          state_d = S_COMPUTE;
        end else begin
          fire_d = both_ready_c;
        end
      end
      S_COMPUTE: begin
        if (engine_done_i || limit_hit_c) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (sink_done_seen_q || outstream0_done_i) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        state_d = last_tile_c ? S_FINISH : S_CLEAR;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output pulses and levels registered from the next state
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      clear_q  <= 1'b0;
      fire_q   <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      clear_q  <= (state_d == S_CLEAR);
      fire_q   <= fire_d;
      enable_q <= (state_d == S_COMPUTE) || (state_d == S_DRAIN);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_FINISH);
    end
  end

  // Job configuration, tile addresses, iteration index and sticky sink-done flag
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      nb_iter_q        <= '0;
      cnt_limit_q      <= '0;
      in_stride_q      <= '0;
      out_stride_q     <= '0;
      iter_q           <= '0;
      in_addr_q        <= '0;
      out_addr_q       <= '0;
      sink_done_seen_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            nb_iter_q    <= nb_iter_i;
            cnt_limit_q  <= cnt_limit_i;
            in_stride_q  <= instream0_tile_stride_i;
            out_stride_q <= outstream0_tile_stride_i;
            in_addr_q    <= instream0_base_i;
            out_addr_q   <= outstream0_base_i;
            iter_q       <= '0;
          end
        end
        S_CLEAR: begin
          sink_done_seen_q <= 1'b0;
        end
        S_LAUNCH, S_COMPUTE, S_DRAIN: begin
          if (outstream0_done_i) begin
            sink_done_seen_q <= 1'b1;
          end
        end
        S_UPDATE: begin
          if (!last_tile_c) begin
            iter_q     <= iter_q + NB_ITER_W'(1);
            in_addr_q  <= in_addr_q + in_stride_q;
            out_addr_q <= out_addr_q + out_stride_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign engine_clear_o         = clear_q;
  assign instream0_req_start_o  = fire_q;
  assign outstream0_req_start_o = fire_q;
  assign engine_start_o         = fire_q;
  assign engine_enable_o        = enable_q;
  assign busy_o                 = busy_q;
  assign done_o                 = done_q;
  assign iter_o                 = iter_q;
  assign instream0_addr_o       = in_addr_q;
  assign outstream0_addr_o      = out_addr_q;

endmodule
